// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the integrator / comb chain.
package dsp_pkg;

    // Default sample width for the chain.
    localparam int DSP_W = 32;

    // Reset value of every integrator and comb delay entry; keeping them equal
    // makes the first comb difference after reset zero for a quiescent chain.
    localparam logic [31:0] DSP_INIT = 32'h4001_0000;

    // Bits needed to count 0..n-1, never less than one so that degenerate
    // sizes (n == 1) still get a legal vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comb_delay_line.sv
// M-deep circular delay line for the comb stage. rdata is the oldest entry
// (the one at the write pointer), so a write on the same edge replaces it.
module comb_delay_line
    import dsp_pkg::*;
#(
    parameter int             W    = DSP_W,
    parameter int             M    = 1,
    parameter logic [W-1:0]   INIT = W'(DSP_INIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    generate
        if (M == 1) begin : g_single
            logic [W-1:0] dl;

            // Single-entry line: the pointer never moves.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       dl <= INIT;
                else if (clr)   dl <= INIT;
                else if (we)    dl <= wdata;
            end

            assign rdata = dl;
        end else begin : g_ring
            localparam int PW = clog2(M);

            logic [W-1:0]  dl [M];
            logic [PW-1:0] ptr;

            // Ring write with wrap at M-1; every entry preloads to INIT.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < M; i++) dl[i] <= INIT;
                    ptr <= '0;
                end else if (clr) begin
                    for (int i = 0; i < M; i++) dl[i] <= INIT;
                    ptr <= '0;
                end else if (we) begin
                    dl[ptr] <= wdata;
                    ptr     <= (ptr == PW'(M - 1)) ? '0 : ptr + 1'b1;
                end
            end

            assign rdata = dl[ptr];
        end
    endgenerate

endmodule

// File: rtl/delay_differentiator.sv
// Comb stage: y = x[k] - x[k-M] on every R-th accepted sample, with a
// single registered output behind a valid/ready handshake.
module delay_differentiator
    import dsp_pkg::*;
#(
    parameter int             W    = DSP_W,
    parameter int             M    = 1,
    parameter int             R    = 1,
    parameter logic [W-1:0]   INIT = W'(DSP_INIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         primed
);

    localparam int DW  = clog2(R);
    localparam int PCW = clog2(M + 1);

    logic [DW-1:0]  dcnt;
    logic [PCW-1:0] pcnt;
    logic [W-1:0]   dl_rdata;
    logic           accept;
    logic           keep;

    // A pending result blocks the input unless it leaves this cycle, which
    // also freezes every counter while the output is stalled.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign keep     = accept && (dcnt == DW'(R - 1));
    assign primed   = (pcnt == PCW'(M));

    comb_delay_line #(
        .W    (W),
        .M    (M),
        .INIT (INIT)
    ) u_dl (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (keep),
        .wdata (in_data),
        .rdata (dl_rdata)
    );

    // Decimation phase and saturating history count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
            pcnt <= '0;
        end else if (clr) begin
            dcnt <= '0;
            pcnt <= '0;
        end else if (accept) begin
            if (keep) begin
                dcnt <= '0;
                if (!primed) pcnt <= pcnt + 1'b1;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Output register: a keep loads a new difference even in the cycle the
    // previous one transfers, so back-to-back results need no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (keep) begin
            out_data  <= in_data - dl_rdata;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
